// File: rtl/seq_div_8x4_if.sv
// ============================================================================
//  Module      : seq_div_8x4_if
//  Description : Operand/result bundle for the 8-by-4 sequential divider.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface seq_div_8x4_if;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

`default_nettype wire

// File: rtl/seq_div_8x4.sv
// ============================================================================
//  Module      : seq_div_8x4
//  Description : Restoring 8-bit / 4-bit unsigned divider, one quotient bit per
//                clock, MSB first. Define DIV_ZERO_CHECK_EN for an early exit
//                and flag on a zero divisor.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_div_8x4 (
  input  logic          clk,
  input  logic          rst_n,
  seq_div_8x4_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] dvd_q, dvd_d;
  logic [3:0] dvs_q, dvs_d;
  logic [3:0] part_q, part_d;
  logic [6:0] qacc_q, qacc_d;
  logic [7:0] quot_q, quot_d;
  logic [3:0] rem_q, rem_d;

  logic [4:0] trial;
  logic [3:0] diff;
  logic       qbit;
  logic [3:0] r_next;

`ifdef DIV_ZERO_CHECK_EN
  logic dbz_q, dbz_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    part_d  = part_q;
    qacc_d  = qacc_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
`ifdef DIV_ZERO_CHECK_EN
    dbz_d   = dbz_q;
`endif

    // Low 4 bits of the subtraction are exact whenever trial >= divisor.
    trial  = {part_q, dvd_q[7]};
    qbit   = (trial >= {1'b0, dvs_q});
    diff   = trial[3:0] - dvs_q;
    r_next = qbit ? diff : trial[3:0];

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d = CALC;
          cnt_d   = 3'd0;
          part_d  = 4'd0;
          qacc_d  = 7'd0;
          dvd_d   = bus.dividend;
          dvs_d   = bus.divisor;
`ifdef DIV_ZERO_CHECK_EN
          dbz_d   = 1'b0;
          if (bus.divisor == 4'd0) begin
            state_d = DONE;
            quot_d  = 8'hFF;
            rem_d   = bus.dividend[3:0];
            dbz_d   = 1'b1;
          end
`endif
        end
      end
      CALC: begin
        part_d = r_next;
        dvd_d  = {dvd_q[6:0], 1'b0};
        qacc_d = {qacc_q[5:0], qbit};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          quot_d  = {qacc_q, qbit};
          rem_d   = r_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      dvd_q   <= 8'd0;
      dvs_q   <= 4'd0;
      part_q  <= 4'd0;
      qacc_q  <= 7'd0;
      quot_q  <= 8'd0;
      rem_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      qacc_q  <= qacc_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) dbz_q <= 1'b0;
    else        dbz_q <= dbz_d;
  end
  assign bus.div_by_zero = dbz_q;
`else
  assign bus.div_by_zero = 1'b0;
`endif

  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.busy      = (state_q == CALC);
  assign bus.done      = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_seq_div_8x4.sv
// ============================================================================
//  Module      : tb_seq_div_8x4
//  Description : Directed self-checking bench for seq_div_8x4.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_div_8x4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  seq_div_8x4_if bus ();

  seq_div_8x4 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Drives a start for one edge; returns just after that (accepting) edge.
  task automatic start_op(input logic [7:0] a, input logic [3:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.start    = 1'b0;
  endtask

  // lat = number of edges from the accepting edge up to and including the one
  // after which done is seen (1 = done right after the start edge).
  task automatic wait_done(input int lat_in, output int lat);
    lat = lat_in;
    while (bus.done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic seen;
    bus.start    = 1'b0;
    bus.dividend = 8'd0;
    bus.divisor  = 4'd0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_quot", bus.quotient, 0);
    check("rst_rem", bus.remainder, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 100 / 7
    start_op(8'd100, 4'd7);
    check("busy_calc", bus.busy, 1);
    check("done_calc", bus.done, 0);
    wait_done(1, lat);
    check("lat_100_7", lat, 9);
    check("busy_done", bus.busy, 0);
    check("q_100_7", bus.quotient, 14);
    check("r_100_7", bus.remainder, 2);
    check("dbz_100_7", bus.div_by_zero, 0);
    @(posedge clk); #1;
    check("done_pulse", bus.done, 0);
    repeat (3) @(posedge clk);
    #1;
    check("hold_q", bus.quotient, 14);
    check("hold_r", bus.remainder, 2);

    // 255 / 15 then back-to-back 5 / 9 started in the DONE cycle
    start_op(8'd255, 4'd15);
    wait_done(1, lat);
    check("lat_255_15", lat, 9);
    check("q_255_15", bus.quotient, 17);
    check("r_255_15", bus.remainder, 0);
    start_op(8'd5, 4'd9);
    check("b2b_busy", bus.busy, 1);
    wait_done(1, lat);
    check("lat_5_9", lat, 9);
    check("q_5_9", bus.quotient, 0);
    check("r_5_9", bus.remainder, 5);
    @(posedge clk); #1;

    // 200 / 0
    start_op(8'd200, 4'd0);
    wait_done(1, lat);
`ifdef DIV_ZERO_CHECK_EN
    check("lat_div0", lat, 1);
    check("dbz_div0", bus.div_by_zero, 1);
`else
    check("lat_div0", lat, 9);
    check("dbz_div0", bus.div_by_zero, 0);
`endif
    check("q_div0", bus.quotient, 255);
    check("r_div0", bus.remainder, 8);
    @(posedge clk); #1;

    // start during CALC (edge k+3) is ignored
    start_op(8'd100, 4'd7);
    repeat (2) @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.dividend = 8'd50;
    bus.divisor  = 4'd3;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    wait_done(4, lat);
    check("lat_ign", lat, 9);
    check("q_ign", bus.quotient, 14);
    check("r_ign", bus.remainder, 2);
    check("dbz_ign", bus.div_by_zero, 0);
    @(posedge clk); #1;

    // reset at edge k+4, with a start offered on that same edge
    start_op(8'd100, 4'd7);
    repeat (3) @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.start    = 1'b1;
    bus.dividend = 8'd9;
    bus.divisor  = 4'd2;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    check("mrst_quot", bus.quotient, 0);
    check("mrst_rem", bus.remainder, 0);
    check("mrst_busy", bus.busy, 0);
    check("mrst_done", bus.done, 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      seen = seen | bus.done | bus.busy;
    end
    check("mrst_idle", seen, 0);
    start_op(8'd9, 4'd2);
    wait_done(1, lat);
    check("lat_9_2", lat, 9);
    check("q_9_2", bus.quotient, 4);
    check("r_9_2", bus.remainder, 1);
    @(posedge clk); #1;

    // sweep of random operand pairs against the arithmetic identity
    for (int n = 0; n < 1000; n++) begin
      logic [7:0] a;
      logic [3:0] b;
      a = 8'($urandom_range(0, 255));
      b = 4'($urandom_range(1, 15));
      start_op(a, b);
      wait_done(1, lat);
      check("sweep_q", bus.quotient, 32'(a / b));
      check("sweep_r", bus.remainder, 32'(a % b));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
